shift_iter_ctrl: RTL

- Iterative sequencer wrapped around the team's 8-bit combinational barrel shifter.
- Takes one shift command through a valid/ready handshake and drives the shifter inputs from an accumulator register.
- Writes the shifter result back into the accumulator for a programmable number of repetitions.
- Presents the final value on a valid/ready result port. It is both the upstream feeder and the downstream consumer of the shifter.

---
 rtl/shift_iter_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/shift_iter_ctrl.sv
// shift_iter_ctrl
//
// Iterative sequencer around the external 8-bit combinational barrel shifter.
// One command is taken on the start handshake. The accumulator is then fed
// to the shifter and the shifter result is written back once per clock, for
// rep_in iterations. The final accumulator value is offered on the result
// handshake.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   flush           synchronous abort to IDLE; any pending result is dropped
//   start_valid/
//   start_ready     command handshake; start_ready is high only in IDLE
//   data_in         initial operand
//   op_in           shift op (00 shl, 01 lsr, 10 asr, 11 ror), passed through
//   amt_in          shift amount per iteration
//   rep_in          number of iterations (0 = return data_in unchanged)
//   sh_in/sh_num/
//   sh_ctl          shifter inputs, driven only from registers
//   sh_out          shifter result
//   res_valid/
//   res_ready       result handshake
//   res_data        final accumulator value (meaningful while res_valid)
//   res_zero        res_valid && res_data == 0
//   busy            controller not in IDLE
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a command, start_ready high
// RUN   | one shifter iteration per clock, cnt counts remaining iterations
// DONE  | result held on res_data until res_ready

module shift_iter_ctrl #(
    parameter int DW    = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [DW-1:0]    data_in,
    input  logic [1:0]       op_in,
    input  logic [2:0]       amt_in,
    input  logic [REP_W-1:0] rep_in,
    output logic [DW-1:0]    sh_in,
    output logic [2:0]       sh_num,
    output logic [1:0]       sh_ctl,
    input  logic [DW-1:0]    sh_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DW-1:0]    res_data,
    output logic             res_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [DW-1:0]      acc_q,       acc_d;
    logic [REP_W-1:0]   cnt_q,       cnt_d;
    logic [1:0]         op_q,        op_d;
    logic [2:0]         amt_q,       amt_d;
    logic               res_valid_q, res_valid_d;
    logic               res_zero_q,  res_zero_d;
    logic               busy_q,      busy_d;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        amt_d   = amt_q;

        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    acc_d   = data_in;
                    op_d    = op_in;
                    amt_d   = amt_in;
                    cnt_d   = rep_in;
                    // A zero repetition count skips RUN so cnt never underflows.
                    state_d = (rep_in != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                acc_d = sh_out;
                cnt_d = cnt_q - REP_W'(1);
                if (cnt_q == REP_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over accept, iteration and result handshake.
        if (flush) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end

        // Status outputs are registered from the next-state values so they
        // line up with state_q without a decode after the flops.
        res_valid_d = (state_d == DONE);
        res_zero_d  = (state_d == DONE) && (acc_d == '0);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            amt_q       <= '0;
            res_valid_q <= 1'b0;
            res_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            amt_q       <= amt_d;
            res_valid_q <= res_valid_d;
            res_zero_q  <= res_zero_d;
            busy_q      <= busy_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign sh_in       = acc_q;
    assign sh_num      = amt_q;
    assign sh_ctl      = op_q;
    assign res_valid   = res_valid_q;
    assign res_data    = acc_q;
    assign res_zero    = res_zero_q;
    assign busy        = busy_q;

endmodule
